// File: rtl/hv_wdg_rsp.sv
// Purpose : HV-side watchdog responder. Each valid LV watchdog frame causes one
//           response request to the OWT transmitter after RSP_DLY cycles. A timeout
//           flag is raised when no valid frame arrives within the selected window.
// Latency : rx_vld in cycle N -> o_wdg_owt_tx_req high in cycle N+1+RSP_DLY.
//           The request drops in the cycle after the ack.
// Backpr. : o_wdg_owt_tx_req is a level held until i_owt_tx_wdg_ack. Frames that
//           arrive while a response is in flight collapse into one pending response.
//
// Optional feature: define HV_WDG_CRC_ERR_CNT_EN to count consecutive CRC-failed
// frames and raise o_wdg_crc_err. Without the macro, o_wdg_crc_err is tied to 0.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_wdg_en              block enable; 0 clears all state on the next edge
//   i_owt_rx_wdg_vld      pulse: valid LV watchdog frame received
//   i_owt_rx_crc_err      pulse: LV frame received with CRC failure
//   o_wdg_owt_tx_req      response request (level, held until ack)
//   i_owt_tx_wdg_ack      pulse: transmitter accepted the response
//   i_wdgtmo_config       selects the timeout window WDG_TMO_TH0..3
//   o_wdg_timeout_err     sticky timeout flag, cleared by the next valid frame
//   o_wdg_crc_err         sticky CRC-run flag, cleared by the next valid frame
module hv_wdg_rsp #(
  parameter int WDG_CNT_W   = 16,
  parameter int WDG_TMO_TH0 = 256,
  parameter int WDG_TMO_TH1 = 512,
  parameter int WDG_TMO_TH2 = 1024,
  parameter int WDG_TMO_TH3 = 2048,
  parameter int RSP_DLY     = 4,
  parameter int CRC_ERR_TH  = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_wdg_en,
  input  logic       i_owt_rx_wdg_vld,
  input  logic       i_owt_rx_crc_err,
  output logic       o_wdg_owt_tx_req,
  input  logic       i_owt_tx_wdg_ack,
  input  logic [1:0] i_wdgtmo_config,
  output logic       o_wdg_timeout_err,
  output logic       o_wdg_crc_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DLY  = 2'd1,
    ST_REQ  = 2'd2
  } state_e;

  // Timeout compares against THn-1 so the flag appears in cycle THn after the last clear.
  localparam logic [WDG_CNT_W-1:0] TMO_LIM0 = WDG_CNT_W'(WDG_TMO_TH0 - 1);
  localparam logic [WDG_CNT_W-1:0] TMO_LIM1 = WDG_CNT_W'(WDG_TMO_TH1 - 1);
  localparam logic [WDG_CNT_W-1:0] TMO_LIM2 = WDG_CNT_W'(WDG_TMO_TH2 - 1);
  localparam logic [WDG_CNT_W-1:0] TMO_LIM3 = WDG_CNT_W'(WDG_TMO_TH3 - 1);
  localparam logic [WDG_CNT_W-1:0] DLY_LAST = WDG_CNT_W'((RSP_DLY > 0) ? (RSP_DLY - 1) : 0);
  localparam bit                   NO_DLY   = (RSP_DLY == 0);

  state_e                 state_q, state_d;
  logic [WDG_CNT_W-1:0]   dly_cnt_q, dly_cnt_d;
  logic                   pend_q, pend_d;
  logic                   req_q, req_d;
  logic [WDG_CNT_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic                   tmo_err_q, tmo_err_d;
  logic [WDG_CNT_W-1:0]   tmo_lim;
  logic                   tmo_hit;

  always_comb begin
    tmo_lim = TMO_LIM0;
    case (i_wdgtmo_config)
      2'd0: tmo_lim = TMO_LIM0;
      2'd1: tmo_lim = TMO_LIM1;
      2'd2: tmo_lim = TMO_LIM2;
      2'd3: tmo_lim = TMO_LIM3;
      default: tmo_lim = TMO_LIM0;
    endcase
  end

  // >= rather than == so that switching to a shorter window with a count
  // already past it still fires immediately.
  assign tmo_hit = (tmo_cnt_q >= tmo_lim);

  always_comb begin
    state_d   = state_q;
    dly_cnt_d = dly_cnt_q;
    pend_d    = pend_q;
    tmo_cnt_d = tmo_cnt_q;
    tmo_err_d = tmo_err_q;

    case (state_q)
      ST_IDLE: begin
        if (i_owt_rx_wdg_vld) begin
          dly_cnt_d = '0;
          state_d   = NO_DLY ? ST_REQ : ST_DLY;
        end
      end
      ST_DLY: begin
        if (i_owt_rx_wdg_vld) pend_d = 1'b1;
        if (dly_cnt_q == DLY_LAST) state_d = ST_REQ;
        else                       dly_cnt_d = dly_cnt_q + WDG_CNT_W'(1);
      end
      ST_REQ: begin
        if (i_owt_rx_wdg_vld) pend_d = 1'b1;
        if (i_owt_tx_wdg_ack) begin
          // A frame arriving in the ack cycle counts as pending and is
          // consumed by the restart right away.
          if (pend_q || i_owt_rx_wdg_vld) begin
            pend_d    = 1'b0;
            dly_cnt_d = '0;
            state_d   = NO_DLY ? ST_REQ : ST_DLY;
          end else begin
            state_d   = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Timeout counter holds once the live window is reached.
    if (i_owt_rx_wdg_vld) begin
      tmo_cnt_d = '0;
      tmo_err_d = 1'b0;
    end else if (tmo_hit) begin
      tmo_err_d = 1'b1;
    end else begin
      tmo_cnt_d = tmo_cnt_q + WDG_CNT_W'(1);
    end

    if (!i_wdg_en) begin
      state_d   = ST_IDLE;
      dly_cnt_d = '0;
      pend_d    = 1'b0;
      tmo_cnt_d = '0;
      tmo_err_d = 1'b0;
    end

    req_d = (state_d == ST_REQ);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      dly_cnt_q <= '0;
      pend_q    <= 1'b0;
      req_q     <= 1'b0;
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dly_cnt_q <= dly_cnt_d;
      pend_q    <= pend_d;
      req_q     <= req_d;
      tmo_cnt_q <= tmo_cnt_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign o_wdg_owt_tx_req  = req_q;
  assign o_wdg_timeout_err = tmo_err_q;

`ifdef HV_WDG_CRC_ERR_CNT_EN
  localparam int                    CRC_CNT_W = $clog2(CRC_ERR_TH + 1);
  localparam logic [CRC_CNT_W-1:0]  CRC_MAX   = CRC_CNT_W'(CRC_ERR_TH);
  localparam logic [CRC_CNT_W-1:0]  CRC_LAST  = CRC_CNT_W'(CRC_ERR_TH - 1);

  logic [CRC_CNT_W-1:0] crc_cnt_q, crc_cnt_d;
  logic                 crc_err_q, crc_err_d;

  always_comb begin
    crc_cnt_d = crc_cnt_q;
    crc_err_d = crc_err_q;
    // A valid frame ends the run even if a CRC error is flagged in the same cycle.
    if (i_owt_rx_wdg_vld) begin
      crc_cnt_d = '0;
      crc_err_d = 1'b0;
    end else if (i_owt_rx_crc_err) begin
      if (crc_cnt_q < CRC_MAX)   crc_cnt_d = crc_cnt_q + CRC_CNT_W'(1);
      if (crc_cnt_q >= CRC_LAST) crc_err_d = 1'b1;
    end
    if (!i_wdg_en) begin
      crc_cnt_d = '0;
      crc_err_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      crc_cnt_q <= '0;
      crc_err_q <= 1'b0;
    end else begin
      crc_cnt_q <= crc_cnt_d;
      crc_err_q <= crc_err_d;
    end
  end

  assign o_wdg_crc_err = crc_err_q;
`else
  logic crc_unused;
  assign crc_unused    = i_owt_rx_crc_err;
  assign o_wdg_crc_err = 1'b0;
`endif

endmodule
